aibnd_avmm_clkrst_seq: RTL and testbench
========================================

# aibnd_avmm_clkrst_seq

Sequencer for the AVMM-derived PCS clock and reset. After `avmm_rstb` releases, it enables the PCS clock gate and then releases the PCS reset after a fixed settle delay. It also handles software reset and clock-stop requests with a four-phase acknowledge, so the PCS clock always runs while reset is applied and is never gated while the PCS is out of reset. It sits between the AVMM reset synchronizer and the PCS clock gate / reset buffer in each aibnd channel.

## Interface
Parameters:
- `CLK_DLY`, default 8: cycles `pcs_clk_en` is high before `pcs_rstb` rises; must be ≥1.
- `RST_HOLD`, default 4: minimum cycles `pcs_rstb` is held low, with the clock running, on entry to reset; must be ≥1.
- `CNT_W`, default 8: delay counter width; both delays must be ≤ 2^CNT_W.

Ports:
- `avmm_clk`  in  1  sequencer clock; this is the only clock.
- `avmm_rstb`  in  1  asynchronous active-low reset.
- `sw_rst_req`  in  1  level request to place the PCS in reset; synchronous to `avmm_clk`.
- `clk_stop_req`  in  1  level request to reset the PCS and then gate its clock; synchronous.
- `pcs_clk_en`  out  1  PCS clock gate enable; registered.
- `pcs_rstb`  out  1  PCS reset, active-low; registered.
- `seq_ready`  out  1  high when the PCS is running (S_RUN); registered.
- `rst_ack`  out  1  acknowledge for `sw_rst_req`; registered.
- `seq_state`  out  3  current state encoding, for debug.

## Operation
- Reset values: `pcs_clk_en`=0, `pcs_rstb`=0, `seq_ready`=0, `rst_ack`=0, state=S_OFF, counter=0.
- S_OFF (clk_en 0, rstb 0):
  - If `clk_stop_req`=0, go to S_CLKON and load counter with CLK_DLY-1.
  - Otherwise stay in S_OFF.
- S_CLKON (clk_en 1, rstb 0): decrement the counter each cycle.
  - If `clk_stop_req`=1, go to S_HOLD immediately and load RST_HOLD-1.
  - Else, on counter==0, go to S_RUN.
- S_RUN (clk_en 1, rstb 1, ready 1): if `clk_stop_req` or `sw_rst_req` is high, go to S_HOLD and load RST_HOLD-1.
- S_HOLD (clk_en 1, rstb 0): decrement the counter to 0, then:
  - If `clk_stop_req`=1, go to S_GATE.
  - Else if `sw_rst_req`=1, stay in S_HOLD and set `rst_ack`=1.
  - Else go to S_CLKON and load CLK_DLY-1.
- S_GATE (clk_en 0, rstb 0): one cycle, then go to S_OFF. The gate always closes one full cycle after reset has been held.
- Handshake: `rst_ack` rises only after the RST_HOLD hold completes. It stays high while `sw_rst_req`=1 and falls on the edge after `sw_rst_req` is seen low. The return to S_CLKON happens on that same edge.
- Priority: `clk_stop_req` overrides `sw_rst_req` in every state. If `clk_stop_req` is raised while `rst_ack`=1, `rst_ack` drops and the sequencer proceeds to S_GATE.
- `pcs_rstb`=1 is only legal when `pcs_clk_en`=1 and the state is S_RUN.
- Asserting `avmm_rstb` at any point forces all outputs to their reset values asynchronously. No draining occurs.

## Timing
- E0 is the first rising edge with `avmm_rstb` high and `clk_stop_req`=0.
  - `pcs_clk_en`=1 after E0.
  - `pcs_rstb`=1 and `seq_ready`=1 after edge E(CLK_DLY).
- From S_RUN: if a request is sampled at edge Ei, `pcs_rstb`=0 and `seq_ready`=0 after Ei.
  - `rst_ack`=1 after Ei+RST_HOLD.
  - With `clk_stop_req`, `pcs_clk_en`=0 after Ei+RST_HOLD.
- Release: if `sw_rst_req`=0 is sampled at edge Ej, `rst_ack`=0 and state=S_CLKON after Ej, and `pcs_rstb`=1 after Ej+CLK_DLY.
- All outputs come straight from flops, with no combinational input-to-output paths.

## Structure
- Shared include `aibnd_avmm_seq_pkg.vh` holds the state localparams: S_OFF=0, S_CLKON=1, S_RUN=2, S_HOLD=3, S_GATE=4. The verification bench reuses these.
- One sub-module, `aibnd_avmm_seq_cnt`: a CNT_W-bit load/decrement counter with `load`, `ld_val`, `dec`, `zero`, reset to 0.
- The top level holds the state register, next-state logic and registered outputs.

## Test plan
- Power-up, CLK_DLY=8, requests low: `pcs_clk_en` rises after E0, `pcs_rstb` and `seq_ready` rise after E8, `rst_ack` stays 0.
- SW reset, RST_HOLD=4: raise `sw_rst_req` in S_RUN at Ei → `pcs_rstb`=0 after Ei, `rst_ack`=1 after Ei+4, clock stays enabled. Drop the request → `rst_ack`=0 on the next edge, `pcs_rstb`=1 eight cycles later.
- Clock stop: raise `clk_stop_req` in S_RUN → `pcs_rstb` low, then after 4 cycles `pcs_clk_en`=0 and state S_OFF. Drop the request → full CLK_DLY power-up sequence.
- Simultaneous requests, plus `clk_stop_req` raised while `rst_ack`=1 → `rst_ack` falls and the clock gates. Assertion: `pcs_rstb`=1 never occurs with `pcs_clk_en`=0.
- `avmm_rstb` pulsed low mid S_CLKON and mid S_HOLD → all outputs 0 immediately, and the sequence restarts from S_OFF.
- Minimum delays, CLK_DLY=1 and RST_HOLD=1: `pcs_rstb` rises after E1, and `rst_ack` rises one edge after the request is sampled.

Source files
------------

// File: rtl/aibnd_avmm_clkrst_seq_pkg.sv
// Shared state encoding for the AVMM-derived PCS clock/reset sequencer.
// The encoding values are visible on seq_state for debug and reused by the bench.
package aibnd_avmm_clkrst_seq_pkg;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_CLKON = 3'd1,
        S_RUN   = 3'd2,
        S_HOLD  = 3'd3,
        S_GATE  = 3'd4
    } seq_state_e;

    // States in which the PCS clock gate is open.
    function automatic logic clk_open(input seq_state_e s);
        return (s == S_CLKON) || (s == S_RUN) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/aibnd_avmm_seq_cnt.sv
// Load/decrement delay counter. It saturates at zero and load wins over decrement.
module aibnd_avmm_seq_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= ld_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/aibnd_avmm_clkrst_seq.sv
// PCS clock-enable / reset sequencer: the clock runs before, during and after reset,
// and it is gated only after a completed reset hold.
module aibnd_avmm_clkrst_seq
    import aibnd_avmm_clkrst_seq_pkg::*;
#(
    parameter int unsigned CLK_DLY  = 8,
    parameter int unsigned RST_HOLD = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       avmm_clk,
    input  logic       avmm_rstb,
    input  logic       sw_rst_req,
    input  logic       clk_stop_req,
    output logic       pcs_clk_en,
    output logic       pcs_rstb,
    output logic       seq_ready,
    output logic       rst_ack,
    output logic [2:0] seq_state
);

    localparam logic [CNT_W-1:0] CLK_LD  = CNT_W'(CLK_DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(RST_HOLD - 1);

    seq_state_e       state_q, state_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_ld_val;
    logic             ack_d;
    logic             clk_en_q, rstb_q, ready_q, ack_q;

    aibnd_avmm_seq_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk   (avmm_clk),
        .rst_n (avmm_rstb),
        .load  (cnt_load),
        .ld_val(cnt_ld_val),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_ld_val = CLK_LD;
        cnt_dec    = 1'b0;
        ack_d      = 1'b0;
        case (state_q)
            S_OFF: begin
                if (!clk_stop_req) begin
                    state_d  = S_CLKON;
                    cnt_load = 1'b1;
                end
            end
            S_CLKON: begin
                if (clk_stop_req) begin
                    state_d    = S_HOLD;
                    cnt_load   = 1'b1;
                    cnt_ld_val = HOLD_LD;
                end else if (cnt_zero) begin
                    state_d = S_RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_RUN: begin
                if (clk_stop_req || sw_rst_req) begin
                    state_d    = S_HOLD;
                    cnt_load   = 1'b1;
                    cnt_ld_val = HOLD_LD;
                end
            end
            S_HOLD: begin
                // The hold always runs to completion before any request is acted on.
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (clk_stop_req) begin
                    state_d = S_GATE;
                end else if (sw_rst_req) begin
                    ack_d = 1'b1;
                end else begin
                    state_d  = S_CLKON;
                    cnt_load = 1'b1;
                end
            end
            S_GATE: begin
                state_d = S_OFF;
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge avmm_clk or negedge avmm_rstb) begin
        if (!avmm_rstb) begin
            state_q  <= S_OFF;
            clk_en_q <= 1'b0;
            rstb_q   <= 1'b0;
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            clk_en_q <= clk_open(state_d);
            rstb_q   <= (state_d == S_RUN);
            ready_q  <= (state_d == S_RUN);
            ack_q    <= ack_d;
        end
    end

    assign pcs_clk_en = clk_en_q;
    assign pcs_rstb   = rstb_q;
    assign seq_ready  = ready_q;
    assign rst_ack    = ack_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_aibnd_avmm_clkrst_seq.sv
// Bench for aibnd_avmm_clkrst_seq: a default-delay and a minimum-delay instance share
// stimulus and are compared every cycle against a phase/elapsed-time reference model.
module tb_aibnd_avmm_clkrst_seq;
    import aibnd_avmm_clkrst_seq_pkg::*;

    localparam int unsigned DLY0  = 8;
    localparam int unsigned HOLD0 = 4;
    localparam int unsigned DLY1  = 1;
    localparam int unsigned HOLD1 = 1;

    logic       clk;
    logic       avmm_rstb;
    logic       sw_rst_req;
    logic       clk_stop_req;
    logic [1:0] clk_en;
    logic [1:0] o_rstb;
    logic [1:0] ready;
    logic [1:0] ack;
    logic [2:0] st [2];

    int checks = 0;
    int errors = 0;

    int unsigned dly  [2] = '{DLY0, DLY1};
    int unsigned hold [2] = '{HOLD0, HOLD1};
    seq_state_e  m_ph [2];
    int unsigned m_el [2];
    logic        m_ack [2];

    aibnd_avmm_clkrst_seq #(.CLK_DLY(DLY0), .RST_HOLD(HOLD0), .CNT_W(8)) u_dut (
        .avmm_clk(clk), .avmm_rstb(avmm_rstb), .sw_rst_req(sw_rst_req),
        .clk_stop_req(clk_stop_req), .pcs_clk_en(clk_en[0]), .pcs_rstb(o_rstb[0]),
        .seq_ready(ready[0]), .rst_ack(ack[0]), .seq_state(st[0])
    );

    aibnd_avmm_clkrst_seq #(.CLK_DLY(DLY1), .RST_HOLD(HOLD1), .CNT_W(8)) u_min (
        .avmm_clk(clk), .avmm_rstb(avmm_rstb), .sw_rst_req(sw_rst_req),
        .clk_stop_req(clk_stop_req), .pcs_clk_en(clk_en[1]), .pcs_rstb(o_rstb[1]),
        .seq_ready(ready[1]), .rst_ack(ack[1]), .seq_state(st[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i]  = S_OFF;
            m_el[i]  = 0;
            m_ack[i] = 1'b0;
        end
    endtask

    // Phase plus cycles-since-phase-entry; hold and clock delays are elapsed-time thresholds.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_ack[i] = 1'b0;
            case (m_ph[i])
                S_OFF: if (!clk_stop_req) begin m_ph[i] = S_CLKON; m_el[i] = 0; end
                S_CLKON: begin
                    if (clk_stop_req) begin
                        m_ph[i] = S_HOLD; m_el[i] = 0;
                    end else begin
                        m_el[i]++;
                        if (m_el[i] >= dly[i]) m_ph[i] = S_RUN;
                    end
                end
                S_RUN: if (clk_stop_req || sw_rst_req) begin m_ph[i] = S_HOLD; m_el[i] = 0; end
                S_HOLD: begin
                    if (m_el[i] < hold[i]) m_el[i]++;
                    if (m_el[i] >= hold[i]) begin
                        if (clk_stop_req)    m_ph[i] = S_GATE;
                        else if (sw_rst_req) m_ack[i] = 1'b1;
                        else begin m_ph[i] = S_CLKON; m_el[i] = 0; end
                    end
                end
                S_GATE: m_ph[i] = S_OFF;
                default: m_ph[i] = S_OFF;
            endcase
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic en_exp, run_exp;
            en_exp  = (m_ph[i] == S_CLKON) || (m_ph[i] == S_RUN) || (m_ph[i] == S_HOLD);
            run_exp = (m_ph[i] == S_RUN);
            chk1($sformatf("u%0d.pcs_clk_en", i), clk_en[i], en_exp);
            chk1($sformatf("u%0d.pcs_rstb", i), o_rstb[i], run_exp);
            chk1($sformatf("u%0d.seq_ready", i), ready[i], run_exp);
            chk1($sformatf("u%0d.rst_ack", i), ack[i], m_ack[i]);
            chk3($sformatf("u%0d.seq_state", i), st[i], m_ph[i]);
            chk1($sformatf("u%0d.rstb_without_clk", i), o_rstb[i] & ~clk_en[i], 1'b0);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (avmm_rstb) model_edge();
            else model_reset();
            #1;
            check_all();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk1($sformatf("%s.u%0d.pcs_clk_en", tag, i), clk_en[i], 1'b0);
            chk1($sformatf("%s.u%0d.pcs_rstb", tag, i), o_rstb[i], 1'b0);
            chk1($sformatf("%s.u%0d.seq_ready", tag, i), ready[i], 1'b0);
            chk1($sformatf("%s.u%0d.rst_ack", tag, i), ack[i], 1'b0);
            chk3($sformatf("%s.u%0d.seq_state", tag, i), st[i], 3'd0);
        end
    endtask

    // Called one time unit after a rising edge; the pulse is entirely between edges.
    task automatic pulse_reset(input string tag);
        #2 avmm_rstb = 1'b0;
        #1 check_reset_outputs(tag);
        model_reset();
        #1 avmm_rstb = 1'b1;
    endtask

    initial begin
        avmm_rstb    = 1'b0;
        sw_rst_req   = 1'b0;
        clk_stop_req = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("por");
        avmm_rstb = 1'b1;

        // Power-up: E0 is the first step.
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk1("pwrup_clk_en_main", clk_en[0], 1'b1);
            chk1("pwrup_rstb_main", o_rstb[0], i >= 8);
            chk1("pwrup_rstb_min", o_rstb[1], i >= 1);
            chk1("pwrup_ack_main", ack[0], 1'b0);
        end

        // Software reset and release.
        sw_rst_req = 1'b1;
        step(1);
        chk1("swrst_rstb_low", o_rstb[0], 1'b0);
        chk1("swrst_clk_kept", clk_en[0], 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk1("swrst_ack_main", ack[0], k >= 4);
            chk1("swrst_ack_min", ack[1], 1'b1);
            chk1("swrst_clk_main", clk_en[0], 1'b1);
        end
        sw_rst_req = 1'b0;
        step(1);
        chk1("release_ack_low", ack[0], 1'b0);
        chk3("release_state", st[0], S_CLKON);
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk1("release_rstb_main", o_rstb[0], k >= 8);
            chk1("release_rstb_min", o_rstb[1], 1'b1);
        end

        // Clock stop from run, then full power-up on release.
        clk_stop_req = 1'b1;
        step(1);
        chk1("stop_rstb_low", o_rstb[0], 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            chk1("stop_clk_en_main", clk_en[0], k < 4);
        end
        chk3("stop_state_off", st[0], S_OFF);
        step(2);
        clk_stop_req = 1'b0;
        step(12);

        // Simultaneous requests.
        sw_rst_req   = 1'b1;
        clk_stop_req = 1'b1;
        step(8);
        sw_rst_req   = 1'b0;
        clk_stop_req = 1'b0;
        step(12);

        // Clock stop while the reset is acknowledged.
        sw_rst_req = 1'b1;
        step(6);
        chk1("ack_before_stop", ack[0], 1'b1);
        clk_stop_req = 1'b1;
        step(1);
        chk1("stop_drops_ack", ack[0], 1'b0);
        chk1("stop_gates_clk", clk_en[0], 1'b0);
        step(2);
        sw_rst_req   = 1'b0;
        clk_stop_req = 1'b0;
        step(12);

        // Asynchronous reset mid S_CLKON.
        clk_stop_req = 1'b1;
        step(8);
        clk_stop_req = 1'b0;
        step(3);
        chk3("pre_rst_clkon", st[0], S_CLKON);
        pulse_reset("rst_in_clkon");
        step(12);

        // Asynchronous reset mid S_HOLD.
        sw_rst_req = 1'b1;
        step(2);
        chk3("pre_rst_hold", st[0], S_HOLD);
        pulse_reset("rst_in_hold");
        sw_rst_req = 1'b0;
        step(12);

        // Randomized sticky requests with occasional reset pulses.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) < 12) sw_rst_req = ~sw_rst_req;
            if ($urandom_range(0, 99) < 8)  clk_stop_req = ~clk_stop_req;
            if ($urandom_range(0, 99) < 2)  pulse_reset("rst_random");
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
